// File: rtl/AFU_PKG.sv
// AFU-side types: the arbitrated command line and the issue-stage FSM states.
package AFU_PKG;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    ISSUE,
    FLUSH
  } command_issue_state;

  typedef struct packed {
    logic        valid;
    logic [7:0]  tag;
    logic [12:0] command;
    logic [63:0] address;
    logic [11:0] size;
  } CommandBufferLine;

endpackage

// File: rtl/CAPI_PKG.sv
// PSL-facing types, the shared credit width and the odd-parity helper
// used when driving the PSL command interface.
package CAPI_PKG;

  localparam int CAPI_CREDIT_WIDTH = 9;

  typedef struct packed {
    logic [7:0] room;
  } CommandInterfaceInput;

  typedef struct packed {
    logic        valid;
    logic [7:0]  tag;
    logic        tag_parity;
    logic [12:0] command;
    logic        command_parity;
    logic [2:0]  abt;
    logic [63:0] address;
    logic        address_parity;
    logic [15:0] context_handle;
    logic [11:0] size;
  } CommandInterfaceOutput;

  // Only the response fields consumed by the command issue path.
  typedef struct packed {
    logic                                valid;
    logic signed [CAPI_CREDIT_WIDTH-1:0] credits;
  } ResponseInterface;

  function automatic logic odd_parity(input logic [63:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/fifo_command_line.sv
// Synchronous FIFO of command lines; a push into a full FIFO is dropped,
// and clear empties it in one cycle.
module fifo_command_line
  import AFU_PKG::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     rstn,
  input  logic                     clear,
  input  logic                     push,
  input  CommandBufferLine         data_in,
  input  logic                     pop,
  output CommandBufferLine         data_out,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  CommandBufferLine mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CNT_FULL);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign data_out = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= data_in;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/command_issue_control.sv
// Credit-gated issue stage: queues arbitrated command lines and drives one
// registered PSL command per cycle while PSL command credits remain.
module command_issue_control
  import CAPI_PKG::*;
  import AFU_PKG::*;
#(
  parameter int FIFO_DEPTH   = 16,
  parameter int CREDIT_WIDTH = CAPI_CREDIT_WIDTH
) (
  input  logic                    clock,
  input  logic                    rstn,
  input  logic                    enabled_in,
  input  CommandInterfaceInput    command_in,
  input  CommandBufferLine        command_line_in,
  input  ResponseInterface        response,
  output CommandInterfaceOutput   command_out,
  output logic                    fifo_almost_full_out,
  output logic [CREDIT_WIDTH-1:0] credit_count_out,
  output logic [1:0]              issue_error_out
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] ALMOST_FULL = (AW+1)'(FIFO_DEPTH - 2);

  command_issue_state             state;
  command_issue_state             next_state;
  logic signed [CREDIT_WIDTH-1:0] credits;
  logic signed [CREDIT_WIDTH-1:0] room_max;
  logic signed [CREDIT_WIDTH-1:0] room_ext;
  logic signed [CREDIT_WIDTH-1:0] credits_next;
  logic signed [CREDIT_WIDTH:0]   resp_add;
  logic signed [CREDIT_WIDTH:0]   credit_sum;
  logic                           credit_avail;
  logic                           push;
  logic                           pop;
  logic                           fifo_empty;
  logic                           fifo_full;
  logic [AW:0]                    fifo_count;
  CommandBufferLine               fifo_head;
  CommandBufferLine               issue_p1;
  logic [1:0]                     error_flags;

  // Sum is one bit wider than the counter so room plus returned credits cannot wrap.
  function automatic logic signed [CREDIT_WIDTH-1:0] clamp_credit(
    input logic signed [CREDIT_WIDTH:0]   sum,
    input logic signed [CREDIT_WIDTH-1:0] limit
  );
    if (sum > (CREDIT_WIDTH+1)'(limit)) return limit;
    return sum[CREDIT_WIDTH-1:0];
  endfunction

  assign room_ext     = $signed(CREDIT_WIDTH'(command_in.room));
  assign credit_avail = !credits[CREDIT_WIDTH-1] && (credits != '0);
  assign push         = command_line_in.valid && (state != FLUSH);
  assign pop          = (state == ISSUE) && enabled_in && !fifo_empty && credit_avail;

  fifo_command_line #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock    (clock),
    .rstn     (rstn),
    .clear    (state == FLUSH),
    .push     (push),
    .data_in  (command_line_in),
    .pop      (pop),
    .data_out (fifo_head),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .count    (fifo_count)
  );

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (enabled_in) next_state = LOAD;
      LOAD:    next_state = ISSUE;
      ISSUE:   if (!enabled_in) next_state = FLUSH;
      FLUSH:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    resp_add = '0;
    if (response.valid) resp_add = (CREDIT_WIDTH+1)'($signed(response.credits));
    credit_sum   = (CREDIT_WIDTH+1)'(credits)
                 - $signed({{CREDIT_WIDTH{1'b0}}, pop}) + resp_add;
    credits_next = clamp_credit(credit_sum, room_max);
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      credits  <= '0;
      room_max <= '0;
    end else begin
      case (state)
        LOAD: begin
          credits  <= room_ext;
          room_max <= room_ext;
        end
        ISSUE:   credits <= credits_next;
        FLUSH:   credits <= '0;
        default: credits <= credits;
      endcase
    end
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      error_flags <= '0;
    end else begin
      if (push && fifo_full) error_flags[0] <= 1'b1;
      if ((state == ISSUE) && (credit_sum > (CREDIT_WIDTH+1)'(room_max)))
        error_flags[1] <= 1'b1;
    end
  end

  // ---- issue register stage (p1) ----
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn)     issue_p1       <= '0;
    else if (pop)  issue_p1       <= fifo_head;
    else           issue_p1.valid <= 1'b0;
  end

  always_comb begin
    command_out                = '0;
    command_out.valid          = issue_p1.valid;
    command_out.tag            = issue_p1.tag;
    command_out.tag_parity     = odd_parity(64'(issue_p1.tag));
    command_out.command        = issue_p1.command;
    command_out.command_parity = odd_parity(64'(issue_p1.command));
    command_out.address        = issue_p1.address;
    command_out.address_parity = odd_parity(issue_p1.address);
    command_out.size           = issue_p1.size;
  end

  assign fifo_almost_full_out = (fifo_count >= ALMOST_FULL);
  assign credit_count_out     = credits;
  assign issue_error_out      = error_flags;

endmodule

// File: tb/tb_command_issue_control.sv
// Directed bench for command_issue_control: credit gating, clamping, FIFO
// overflow, flush on disable, parity and asynchronous reset.
module tb_command_issue_control;
  import CAPI_PKG::*;
  import AFU_PKG::*;

  logic                  clock = 1'b0;
  logic                  rstn;
  logic                  enabled_in;
  CommandInterfaceInput  command_in;
  CommandBufferLine      command_line_in;
  ResponseInterface      response;
  CommandInterfaceOutput command_out;
  logic                  fifo_almost_full_out;
  logic [8:0]            credit_count_out;
  logic [1:0]            issue_error_out;

  int n_cmp = 0;
  int n_mis = 0;

  command_issue_control #(
    .FIFO_DEPTH   (16),
    .CREDIT_WIDTH (9)
  ) dut (
    .clock                (clock),
    .rstn                 (rstn),
    .enabled_in           (enabled_in),
    .command_in           (command_in),
    .command_line_in      (command_line_in),
    .response             (response),
    .command_out          (command_out),
    .fifo_almost_full_out (fifo_almost_full_out),
    .credit_count_out     (credit_count_out),
    .issue_error_out      (issue_error_out)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic set_push(input logic [7:0] tag, input logic [12:0] cmd, input logic [63:0] addr);
    command_line_in         = '0;
    command_line_in.valid   = 1'b1;
    command_line_in.tag     = tag;
    command_line_in.command = cmd;
    command_line_in.address = addr;
    command_line_in.size    = 12'd128;
  endtask

  task automatic set_resp(input logic signed [8:0] c);
    response.valid   = 1'b1;
    response.credits = c;
  endtask

  logic       exp_v   [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  logic [7:0] exp_tag [4] = '{8'h00, 8'h00, 8'h01, 8'h00};
  logic [8:0] exp_cr  [4] = '{9'd2, 9'd1, 9'd0, 9'd0};

  initial begin
    rstn = 1'b0; enabled_in = 1'b0;
    command_in = '0; command_line_in = '0; response = '0;
    step(2);
    check_val("rst_valid",    command_out.valid, 0);
    check_val("rst_tag",      command_out.tag, 0);
    check_val("rst_tag_par",  command_out.tag_parity, 1);
    check_val("rst_addr_par", command_out.address_parity, 1);
    check_val("rst_afull",    fifo_almost_full_out, 0);
    check_val("rst_credit",   credit_count_out, 0);
    check_val("rst_err",      issue_error_out, 0);

    // Room = 2, four back-to-back pushes
    rstn = 1'b1; command_in.room = 8'd2; enabled_in = 1'b1;
    step(2);
    check_val("load_credit", credit_count_out, 2);
    for (int i = 0; i < 4; i++) begin
      set_push(8'(i), 13'h0010, 64'h1000 + 64'(i));
      step();
      check_val($sformatf("burst%0d_valid", i), command_out.valid, exp_v[i]);
      if (exp_v[i]) check_val($sformatf("burst%0d_tag", i), command_out.tag, exp_tag[i]);
      check_val($sformatf("burst%0d_credit", i), credit_count_out, exp_cr[i]);
    end
    command_line_in = '0;
    step();
    check_val("stall_valid", command_out.valid, 0);
    set_resp(9'sd1); step(); response = '0;
    check_val("resp_credit", credit_count_out, 1);
    check_val("resp_valid",  command_out.valid, 0);
    step();
    check_val("third_valid",  command_out.valid, 1);
    check_val("third_tag",    command_out.tag, 8'h02);
    check_val("third_credit", credit_count_out, 0);
    step();
    check_val("stall2_valid", command_out.valid, 0);

    // Pop and +1 credit in the same cycle
    set_resp(9'sd1); step(); response = '0;
    check_val("reseed_credit", credit_count_out, 1);
    set_resp(9'sd1); set_push(8'h04, 13'h0010, 64'h2000);
    step(); response = '0; command_line_in = '0;
    check_val("popresp_tag",    command_out.tag, 8'h03);
    check_val("popresp_valid",  command_out.valid, 1);
    check_val("popresp_credit", credit_count_out, 1);
    step();
    check_val("b2b_valid",  command_out.valid, 1);
    check_val("b2b_tag",    command_out.tag, 8'h04);
    check_val("b2b_credit", credit_count_out, 0);

    // Credit clamp with room = 8
    enabled_in = 1'b0; step();
    check_val("disable_valid", command_out.valid, 0);
    step();
    check_val("flush_credit", credit_count_out, 0);
    command_in.room = 8'd8; enabled_in = 1'b1; step(2);
    check_val("room8_credit", credit_count_out, 8);
    check_val("room8_err",    issue_error_out, 0);
    set_resp(9'sd3); step(); response = '0;
    check_val("clamp_credit", credit_count_out, 8);
    check_val("clamp_err",    issue_error_out, 2'b10);
    step(2);
    check_val("err_sticky", issue_error_out, 2'b10);

    // FIFO overflow with zero credits
    enabled_in = 1'b0; step(2);
    check_val("err_kept_on_disable", issue_error_out, 2'b10);
    command_in.room = 8'd0; enabled_in = 1'b1; step(2);
    check_val("room0_credit", credit_count_out, 0);
    for (int i = 1; i <= 17; i++) begin
      set_push(8'h40 + 8'(i), 13'h0010, 64'(i));
      step();
      if (i == 13) check_val("afull_after13", fifo_almost_full_out, 0);
      if (i == 14) check_val("afull_after14", fifo_almost_full_out, 1);
      if (i == 16) check_val("err_after16",   issue_error_out, 2'b10);
    end
    command_line_in = '0;
    check_val("ovf_err",   issue_error_out, 2'b11);
    check_val("ovf_valid", command_out.valid, 0);

    // Disable with five queued commands
    enabled_in = 1'b0; step(2);
    check_val("flush_afull", fifo_almost_full_out, 0);
    for (int i = 0; i < 5; i++) begin
      set_push(8'h20 + 8'(i), 13'h0010, 64'(i));
      step();
    end
    command_line_in = '0;
    command_in.room = 8'd4; enabled_in = 1'b1; step(2);
    check_val("q5_credit", credit_count_out, 4);
    enabled_in = 1'b0; step();
    check_val("dis_no_issue", command_out.valid, 0);
    step();
    check_val("dis_flush_valid",  command_out.valid, 0);
    check_val("dis_flush_credit", credit_count_out, 0);
    enabled_in = 1'b1; step(3);
    check_val("discarded_valid",  command_out.valid, 0);
    check_val("discarded_credit", credit_count_out, 4);

    // Parity vectors
    set_push(8'h03, 13'h0A00, 64'h0); step();
    set_push(8'h01, 13'h0001, 64'h1); step();
    command_line_in = '0;
    check_val("par1_valid", command_out.valid, 1);
    check_val("par1_tag",   command_out.tag_parity, 1);
    check_val("par1_cmd",   command_out.command_parity, 1);
    check_val("par1_addr",  command_out.address_parity, 1);
    step();
    check_val("par2_tagval", command_out.tag, 8'h01);
    check_val("par2_tag",    command_out.tag_parity, 0);
    check_val("par2_cmd",    command_out.command_parity, 0);
    check_val("par2_addr",   command_out.address_parity, 0);
    check_val("par2_credit", credit_count_out, 2);

    // Asynchronous reset mid-burst
    set_push(8'h50, 13'h0010, 64'h50); step();
    set_push(8'h51, 13'h0010, 64'h51); step();
    command_line_in = '0;
    check_val("pre_rst_valid", command_out.valid, 1);
    #2 rstn = 1'b0;
    #1;
    check_val("arst_valid",  command_out.valid, 0);
    check_val("arst_tag",    command_out.tag, 0);
    check_val("arst_credit", credit_count_out, 0);
    check_val("arst_err",    issue_error_out, 0);
    check_val("arst_afull",  fifo_almost_full_out, 0);
    step();
    rstn = 1'b1;
    step();
    check_val("post_rst_valid",  command_out.valid, 0);
    check_val("post_rst_credit", credit_count_out, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/command_issue_control.md
# command_issue_control

Credit-gated issue stage between the AFU command arbiter and the PSL command interface. It buffers arbitrated command lines in a FIFO and tracks PSL command credits, seeded from `command_in.room` and replenished by `response.credits`. It drives `command_out` one registered command per cycle only while credits remain, and generates odd parity for the command word. It sits directly downstream of `afu_control`'s arbitration and replaces its direct drive of `command_out`.

## Interface
- `FIFO_DEPTH`, default 16: command FIFO entries; must be a power of two and at least 4.
- `CREDIT_WIDTH`, default 9: width of the credit counter; signed, to match `response.credits`.
- `clock` in 1: the single clock.
- `rstn` in 1: reset, asynchronous, active-low.
- `enabled_in` in 1: job running; a falling edge flushes the FIFO and credits.
- `command_in` in `CommandInterfaceInput`: the `room` field is sampled on entry to LOAD.
- `command_line_in` in `CommandBufferLine`: arbitrated command; `valid` is a one-cycle push.
- `response` in `ResponseInterface`: latched PSL response; `valid` and `credits` are used.
- `command_out` out `CommandInterfaceOutput`: the PSL command word with parity.
- `fifo_almost_full_out` out 1: back-pressure to the arbiter.
- `credit_count_out` out `CREDIT_WIDTH`: current credits, for MMIO statistics.
- `issue_error_out` out 2: sticky error flags. Bit 0 is FIFO overflow; bit 1 is credit overflow (credits exceeded room).

## Operation
- FSM states: IDLE, LOAD, ISSUE, FLUSH.
  - IDLE → LOAD when `enabled_in` = 1.
  - LOAD (1 cycle): `credits <= room`, `room_max <= room`, then → ISSUE.
  - ISSUE → FLUSH when `enabled_in` = 0.
  - FLUSH (1 cycle): clears FIFO pointers and credits, then → IDLE.
- Push: `command_line_in.valid` writes the FIFO in any state except FLUSH. A push while count = FIFO_DEPTH is dropped and sets `issue_error_out[0]`.
- Pop: in ISSUE, when the FIFO is not empty and credits > 0, the head is popped and registered into `command_out` with `valid` = 1. `valid` returns to 0 the next cycle unless another pop occurs, so back-to-back issue is allowed.
- Credit update, every cycle in ISSUE: `credits_next = credits − pop + (response.valid ? response.credits : 0)`, using signed CREDIT_WIDTH arithmetic.
  - If `credits_next > room_max`, credits clamp to `room_max` and `issue_error_out[1]` is set.
  - Negative credits cannot occur because pop is gated on credits > 0.
- Responses that arrive in IDLE, LOAD or FLUSH are ignored for credit purposes.
- Parity: `command_out` tag parity, command parity and address parity are each odd parity over their field, computed from the registered field in the same cycle.
- `fifo_almost_full_out` = 1 when count ≥ FIFO_DEPTH − 2. This gives the arbiter's registered push two cycles of slack.
- Simultaneous push and pop leave the count unchanged. Pointers wrap modulo FIFO_DEPTH; count has width $clog2(FIFO_DEPTH)+1.
- Error flags hold until `rstn` is asserted; `enabled_in` does not clear them.

## Timing
- Reset values:
  - `command_out`: all zero (`valid` = 0; parity fields 1, odd parity of zero).
  - `fifo_almost_full_out` = 0.
  - `credit_count_out` = 0.
  - `issue_error_out` = 0.
  - FSM = IDLE; FIFO empty.
- Latency from push to `command_out.valid`: 2 cycles minimum (cycle N write, cycle N+1 pop decision, N+2 output valid), assuming credits > 0 and an empty FIFO.
- Peak throughput: 1 command per cycle.
- `credit_count_out` is registered and reflects the update one cycle after the pop or response.
- `enabled_in` falling mid-burst: the pop is suppressed in the same cycle. Commands already on `command_out` are not retracted. Remaining FIFO entries are discarded in FLUSH.
- Asynchronous reset mid-operation returns everything to reset values immediately. The first pop after release requires a fresh LOAD.

## Structure
- The FSM state enum `command_issue_state` goes in AFU_PKG.
- The odd-parity helper function goes in CAPI_PKG.
- CREDIT_WIDTH default derives from the CAPI_PKG credit width constant.
- One sub-module: `fifo_command_line`, a synchronous FIFO of `CommandBufferLine` parameterised by depth, with push, pop, empty, full and count outputs. This block instantiates it once.

## Test plan
- Room = 2 and 4 commands pushed back-to-back → exactly 2 issues on consecutive cycles, then stall. A response with credits = 1 → the 3rd issue 1 cycle later; `credit_count_out` shows 0.
- Pop and `response.credits` = +1 in the same cycle with credits = 1 → credits stay 1 and issue continues uninterrupted.
- Response credits push the count past room = 8 → credits clamp to 8 and `issue_error_out` = 2'b10, sticky.
- FIFO_DEPTH = 16, credits = 0, 17 pushes → `fifo_almost_full_out` rises after push 14. The 17th push is dropped and `issue_error_out[0]` = 1.
- `enabled_in` deasserted with 5 queued commands → no further `command_out.valid`; FLUSH for 1 cycle then IDLE; count = 0.
- Command tag 0x03, command 0x0A00, address 0x0 → parity bits 1, 1 and 1 respectively. Async reset mid-burst → all outputs zero next sample.
